// File: rtl/button_event_ctrl.sv
// Debounced push-button classifier (SHORT/LONG/REPEAT) with event FIFO and Avalon-MM slave.
// Define BUTTON_EVT_REPEAT_EN to emit auto-REPEAT events while a long press is held.
module button_event_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned LONG_CYCLES     = 50000000,
   parameter int unsigned REPEAT_CYCLES   = 10000000,
   parameter int unsigned FIFO_DEPTH      = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        button_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        read_n,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq
);

   localparam int unsigned MAX_DL = (DEBOUNCE_CYCLES > LONG_CYCLES) ?
                                    DEBOUNCE_CYCLES : LONG_CYCLES;
   localparam int unsigned MAX_C  = (MAX_DL > REPEAT_CYCLES) ?
                                    MAX_DL : REPEAT_CYCLES;
   localparam int CW = $clog2(MAX_C + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = PW + 1;

   localparam logic [CW-1:0] DB_END = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] LG_END = CW'(LONG_CYCLES - 1);
`ifdef BUTTON_EVT_REPEAT_EN
   localparam logic [CW-1:0] RP_END = CW'(REPEAT_CYCLES - 1);
   localparam logic [1:0]    EV_REPEAT = 2'd3;
`endif
   localparam logic [1:0]    EV_SHORT = 2'd1;
   localparam logic [1:0]    EV_LONG  = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DB_PRESS,
      S_HELD,
      S_REPEAT,
      S_DB_REL
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          level, level_n;
   logic          short_pending, sp_n;
   logic          ev_push;
   logic [1:0]    ev_code;

   logic          sync1, sync2;
   logic          pressed;

   logic [1:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [NW-1:0] fifo_cnt;
   logic          fifo_empty, fifo_full;
   logic          rd_req, wr_req;
   logic          do_push, do_pop;
   logic          ovf_set, ovf_clr;
   logic          overflow;
   logic          irq_mask;
   logic [4:0]    cnt5;
   logic [1:0]    head;
   logic [31:0]   rd_mux;
   logic          unused_wdata;

   // Two-flop synchronizer; idles released so reset never looks like a press
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= button_n;
         sync2 <= sync1;
      end
   end

   assign pressed = ~sync2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         level         <= 1'b0;
         short_pending <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         level         <= level_n;
         short_pending <= sp_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      level_n = level;
      sp_n    = short_pending;
      ev_push = 1'b0;
      ev_code = 2'd0;
      unique case (state)
         S_IDLE: begin
            if (pressed) begin
               state_n = S_DB_PRESS;
               cnt_n   = '0;
            end
         end
         S_DB_PRESS: begin
            if (!pressed) begin
               state_n = S_IDLE;
            end else if (cnt == DB_END) begin
               state_n = S_HELD;
               level_n = 1'b1;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_HELD: begin
            if (!pressed) begin
               state_n = S_DB_REL;
               sp_n    = 1'b1;
               cnt_n   = '0;
            end else if (cnt == LG_END) begin
               state_n = S_REPEAT;
               ev_push = 1'b1;
               ev_code = EV_LONG;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_REPEAT: begin
            if (!pressed) begin
               state_n = S_DB_REL;
               sp_n    = 1'b0;
               cnt_n   = '0;
            end
`ifdef BUTTON_EVT_REPEAT_EN
            else if (cnt == RP_END) begin
               ev_push = 1'b1;
               ev_code = EV_REPEAT;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
`endif
         end
         S_DB_REL: begin
            // A bounce back to pressed resumes the hold with a fresh count
            if (pressed) begin
               state_n = short_pending ? S_HELD : S_REPEAT;
               cnt_n   = '0;
            end else if (cnt == DB_END) begin
               ev_push = short_pending;
               ev_code = EV_SHORT;
               level_n = 1'b0;
               state_n = S_IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   assign rd_req     = chipselect & ~read_n & (address == 2'd1);
   assign wr_req     = chipselect & ~write_n;
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == NW'(FIFO_DEPTH));
   assign do_pop     = rd_req & ~fifo_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign do_push    = ev_push & (~fifo_full | do_pop);
   assign ovf_set    = ev_push & fifo_full & ~do_pop;
   assign ovf_clr    = wr_req & (address == 2'd3);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= ev_code;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            fifo_cnt <= fifo_cnt + 1'b1;
         end else if (do_pop && !do_push) begin
            fifo_cnt <= fifo_cnt - 1'b1;
         end
      end
   end

   assign head = mem[rd_ptr];
   assign cnt5 = 5'(fifo_cnt);

   always_comb begin
      rd_mux = '0;
      unique case (address)
         2'd0: rd_mux = {23'd0, cnt5, 2'b00, ~fifo_empty, level};
         2'd1: rd_mux = fifo_empty ? 32'd0 : {30'd0, head};
         2'd2: rd_mux = {31'd0, irq_mask};
         2'd3: rd_mux = {31'd0, overflow};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
         irq_mask <= 1'b0;
         overflow <= 1'b0;
      end else begin
         readdata <= rd_mux;
         if (wr_req && address == 2'd2) begin
            irq_mask <= writedata[0];
         end
         // Set wins over a same-cycle clear so no overflow is lost
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   assign irq          = irq_mask & ~fifo_empty;
   assign unused_wdata = ^writedata[31:1];

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed testbench for button_event_ctrl (DEBOUNCE=4, LONG=20, REPEAT=8, depth 4).
module tb_button_event_ctrl;

   logic        clk;
   logic        reset_n;
   logic        button_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   int checks;
   int failures;

   button_event_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES(20),
      .REPEAT_CYCLES(8),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .button_n(button_n),
      .address(address),
      .chipselect(chipselect),
      .read_n(read_n),
      .write_n(write_n),
      .writedata(writedata),
      .readdata(readdata),
      .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int lo, input int hi);
      button_n = 1'b0;
      tick(lo);
      button_n = 1'b1;
      tick(hi);
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      read_n     = 1'b0;
      tick(1);
      chipselect = 1'b0;
      read_n     = 1'b1;
      d          = readdata;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
      address    = a;
      writedata  = v;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      reset_n = 1'b0;
      tick(3);
      checks++;
      if (readdata !== 32'd0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: readdata=%h irq=%b want 0/0",
                  readdata, irq);
      end
      reset_n = 1'b1;
      tick(2);
      bus_write(2'd1, 32'h3);
      bus_write(2'd0, 32'hffff_ffff);
      bus_read(2'd0, d);
      checks++;
      if (d !== 32'd0) begin
         failures++;
         $display("FAIL reset_status: got %h want 0", d);
      end
      bus_read(2'd2, d);
      checks++;
      if (d !== 32'd0) begin
         failures++;
         $display("FAIL reset_mask: got %h want 0", d);
      end
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'd0) begin
         failures++;
         $display("FAIL reset_ovf: got %h want 0", d);
      end
   endtask

   task automatic test_short_bounce;
      logic [31:0] d;
      press(2, 2);
      press(2, 2);
      press(10, 20);
      bus_read(2'd0, d);
      checks++;
      if (d !== 32'h12) begin
         failures++;
         $display("FAIL short_status: got %h want 00000012", d);
      end
      bus_read(2'd1, d);
      checks++;
      if (d !== 32'd1) begin
         failures++;
         $display("FAIL short_pop: got %h want 1", d);
      end
      bus_read(2'd1, d);
      checks++;
      if (d !== 32'd0) begin
         failures++;
         $display("FAIL short_empty: got %h want 0", d);
      end
   endtask

   task automatic test_long_repeat;
      logic [31:0] d;
      logic [31:0] exp_q[$];
`ifdef BUTTON_EVT_REPEAT_EN
      exp_q = '{32'd2, 32'd3, 32'd3, 32'd0};
`else
      exp_q = '{32'd2, 32'd0};
`endif
      press(45, 20);
      foreach (exp_q[i]) begin
         bus_read(2'd1, d);
         checks++;
         if (d !== exp_q[i]) begin
            failures++;
            $display("FAIL long_read%0d: got %h want %h", i, d, exp_q[i]);
         end
      end
   endtask

   task automatic test_overflow;
      logic [31:0] d;
      repeat (5) press(10, 16);
      bus_read(2'd0, d);
      checks++;
      if (d !== 32'h42) begin
         failures++;
         $display("FAIL ovf_status: got %h want 00000042", d);
      end
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'd1) begin
         failures++;
         $display("FAIL ovf_flag: got %h want 1", d);
      end
      bus_write(2'd3, 32'd0);
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'd0) begin
         failures++;
         $display("FAIL ovf_clear: got %h want 0", d);
      end
      for (int i = 0; i < 5; i++) begin
         bus_read(2'd1, d);
         checks++;
         if (d !== ((i < 4) ? 32'd1 : 32'd0)) begin
            failures++;
            $display("FAIL ovf_read%0d: got %h want %0d", i, d,
                     (i < 4) ? 1 : 0);
         end
      end
   endtask

   task automatic test_irq;
      logic [31:0] d;
      int first;
      bit seen;
      bus_write(2'd2, 32'd1);
      first = -1;
      button_n = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         tick(1);
         if (c == 10) button_n = 1'b1;
         if (irq === 1'b1 && first < 0) first = c;
      end
      checks++;
      if (first != 17) begin
         failures++;
         $display("FAIL irq_rise: cycle %0d want 17", first);
      end
      bus_read(2'd1, d);
      checks++;
      if (d !== 32'd1 || irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_fall: data=%h irq=%b want 1/0", d, irq);
      end
      bus_write(2'd2, 32'd0);
      seen = 1'b0;
      button_n = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         tick(1);
         if (c == 10) button_n = 1'b1;
         if (irq !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL irq_masked: irq rose want 0");
      end
      bus_read(2'd0, d);
      checks++;
      if (d !== 32'h12) begin
         failures++;
         $display("FAIL irq_masked_status: got %h want 00000012", d);
      end
      bus_read(2'd1, d);
   endtask

   task automatic test_glitch;
      logic [31:0] d;
      button_n = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         tick(1);
         if (c == 12) button_n = 1'b1;
         if (c == 14) button_n = 1'b0;
         if (c == 40) button_n = 1'b1;
         if (c == 33 || c == 38) begin
            address    = 2'd0;
            chipselect = 1'b1;
            read_n     = 1'b0;
         end
         if (c == 34) begin
            chipselect = 1'b0;
            read_n     = 1'b1;
            checks++;
            if (readdata !== 32'h01) begin
               failures++;
               $display("FAIL glitch_restart: got %h want 00000001",
                        readdata);
            end
         end
         if (c == 39) begin
            chipselect = 1'b0;
            read_n     = 1'b1;
            checks++;
            if (readdata !== 32'h13) begin
               failures++;
               $display("FAIL glitch_long: got %h want 00000013",
                        readdata);
            end
         end
      end
      bus_read(2'd1, d);
      checks++;
      if (d !== 32'd2) begin
         failures++;
         $display("FAIL glitch_code: got %h want 2", d);
      end
      bus_read(2'd1, d);
      checks++;
      if (d !== 32'd0) begin
         failures++;
         $display("FAIL glitch_noshort: got %h want 0", d);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      bus_write(2'd2, 32'd1);
      press(10, 16);
      press(10, 16);
      bus_read(2'd0, d);
      checks++;
      if (d !== 32'h22 || irq !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre: status=%h irq=%b want 00000022/1", d, irq);
      end
      button_n = 1'b0;
      tick(12);
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if (readdata !== 32'd0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: readdata=%h irq=%b want 0/0",
                  readdata, irq);
      end
      button_n = 1'b1;
      tick(3);
      reset_n = 1'b1;
      tick(1);
      bus_read(2'd0, d);
      checks++;
      if (d !== 32'd0) begin
         failures++;
         $display("FAIL mid_status: got %h want 0", d);
      end
      bus_read(2'd2, d);
      checks++;
      if (d !== 32'd0) begin
         failures++;
         $display("FAIL mid_mask: got %h want 0", d);
      end
      tick(20);
      bus_read(2'd0, d);
      checks++;
      if (d !== 32'd0) begin
         failures++;
         $display("FAIL mid_idle: got %h want 0", d);
      end
   endtask

   initial begin
      clk        = 1'b0;
      reset_n    = 1'b0;
      button_n   = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      read_n     = 1'b1;
      write_n    = 1'b1;
      writedata  = 32'd0;
      checks     = 0;
      failures   = 0;
      test_reset();
      test_short_bounce();
      test_long_repeat();
      test_overflow();
      test_irq();
      test_glitch();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
